// File: rtl/pred_pkg.sv
// Shared definitions for the gshare branch predictor: opcodes, counter
// encodings, FSM state type and 2-bit saturating counter helpers.
package pred_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pred_state_t;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
        return taken ? ctr_inc(c) : ctr_dec(c);
    endfunction

endpackage

// File: rtl/pred_gshare_if.sv
// Fetch-side lookup and execute-side feedback bundle of the gshare predictor.
// Feedback has no back-pressure: a write_enable pulse is consumed on the next
// rising edge once the predictor is in RUN, and ignored while initialising;
// pred_ready_out only qualifies the prediction outputs.
interface pred_gshare_if #(
    parameter int INDEX_BITS = 10
);
    logic [31:0]           pred_addr_in;
    logic [31:0]           pred_ins_in;
    logic                  pred_write_enable_in;
    logic [INDEX_BITS-1:0] pred_indx_in;
    logic                  pred_taken_in;
    logic                  pred_mispredict_in;
    logic                  pred_taken_out;
    logic [31:0]           pred_pc_out;
    logic [INDEX_BITS-1:0] pred_indx_out;
    logic                  pred_ready_out;
    logic [31:0]           pred_miss_count_out;

    modport master (
        output pred_addr_in, pred_ins_in, pred_write_enable_in,
               pred_indx_in, pred_taken_in, pred_mispredict_in,
        input  pred_taken_out, pred_pc_out, pred_indx_out,
               pred_ready_out, pred_miss_count_out
    );

    modport slave (
        input  pred_addr_in, pred_ins_in, pred_write_enable_in,
               pred_indx_in, pred_taken_in, pred_mispredict_in,
        output pred_taken_out, pred_pc_out, pred_indx_out,
               pred_ready_out, pred_miss_count_out
    );

endinterface

// File: rtl/pred_imm_gen.sv
// Combinational decode of RV32 conditional branches and JAL: classifies the
// instruction and produces its sign-extended offset and the PC-relative target.
module pred_imm_gen
    import pred_pkg::*;
(
    input  logic [31:0] ins,
    input  logic [31:0] addr,
    output logic [31:0] imm,
    output logic [31:0] target,
    output logic        is_branch,
    output logic        is_jal
);

    logic unused_ins_bits;
    assign unused_ins_bits = ^ins[1:0];

    always_comb begin
        is_branch = (ins[6:2] == OP_BRANCH);
        is_jal    = (ins[6:2] == OP_JAL);
        imm       = '0;
        if (is_branch) begin
            imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end else if (is_jal) begin
            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
    end

    // Wraps modulo 2^32, matching the fetch PC adder.
    assign target = addr + imm;

endmodule

// File: rtl/pred_gshare.sv
// Gshare direction predictor with a self-initialising 2-bit counter table,
// combinational same-cycle prediction and a saturating mispredict counter.
module pred_gshare
    import pred_pkg::*;
#(
    parameter int          INDEX_BITS = 10,
    parameter int          HIST_BITS  = 8,
    parameter logic [1:0]  INIT_STATE = WNT,
    parameter logic [31:0] MISS_RESET = 32'h0
) (
    input  logic         pred_clock_in,
    input  logic         pred_reset_in,
    pred_gshare_if.slave bus,
    output pred_state_t  fsm_state
);

    localparam int DEPTH = 2 ** INDEX_BITS;
    typedef logic [INDEX_BITS-1:0] idx_t;

    pred_state_t state;
    pred_state_t state_next;
    idx_t        ptr;
    logic        init_active;
    logic        ready;

    logic [1:0]  table_q [DEPTH];
    logic        wr_en;
    idx_t        wr_idx;
    logic [1:0]  wr_data;

    idx_t        hist;
    idx_t        idx;
    logic        upd;
    logic [31:0] miss_count;

    logic [31:0] imm;
    logic [31:0] target;
    logic        is_branch;
    logic        is_jal;
    logic        taken;
    logic [31:0] pc;

    // ---------------- FSM: state register / next state / outputs
    always_ff @(posedge pred_clock_in or posedge pred_reset_in) begin
        if (pred_reset_in) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && ptr == idx_t'(DEPTH - 1)) begin
            state_next = RUN;
        end
    end

    always_comb begin
        init_active = (state == INIT);
        ready       = (state == RUN);
    end

    assign fsm_state = state;

    always_ff @(posedge pred_clock_in or posedge pred_reset_in) begin
        if (pred_reset_in) begin
            ptr <= '0;
        end else if (init_active) begin
            ptr <= ptr + 1'b1;
        end
    end

    // ---------------- global history
    assign upd = ready && bus.pred_write_enable_in;

    generate
        if (HIST_BITS > 0) begin : g_hist
            logic [HIST_BITS-1:0] ghr;
            logic [HIST_BITS:0]   ghr_shift;

            assign ghr_shift = {ghr, bus.pred_taken_in};

            always_ff @(posedge pred_clock_in or posedge pred_reset_in) begin
                if (pred_reset_in) begin
                    ghr <= '0;
                end else if (upd) begin
                    ghr <= ghr_shift[HIST_BITS-1:0];
                end
            end

            assign hist = idx_t'(ghr);
        end else begin : g_bimodal
            assign hist = '0;
        end
    endgenerate

    assign idx = bus.pred_addr_in[INDEX_BITS+1:2] ^ hist;

    // ---------------- counter table, single write port shared by init and update
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr;
        wr_data = INIT_STATE;
        if (init_active) begin
            wr_en = 1'b1;
        end else if (bus.pred_write_enable_in) begin
            wr_en   = 1'b1;
            wr_idx  = bus.pred_indx_in;
            wr_data = ctr_update(table_q[bus.pred_indx_in], bus.pred_taken_in);
        end
    end

    always_ff @(posedge pred_clock_in) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_data;
        end
    end

    // ---------------- mispredict counter
    always_ff @(posedge pred_clock_in or posedge pred_reset_in) begin
        if (pred_reset_in) begin
            miss_count <= MISS_RESET;
        end else if (upd && bus.pred_mispredict_in && miss_count != '1) begin
            miss_count <= miss_count + 32'd1;
        end
    end

    // ---------------- prediction
    pred_imm_gen u_imm (
        .ins       (bus.pred_ins_in),
        .addr      (bus.pred_addr_in),
        .imm       (imm),
        .target    (target),
        .is_branch (is_branch),
        .is_jal    (is_jal)
    );

    // Reads the pre-update counter: an update in the same cycle is not bypassed.
    always_comb begin
        taken = 1'b0;
        pc    = '0;
        if (ready) begin
            taken = is_jal | (is_branch & table_q[idx][1]);
            pc    = taken ? target : 32'h0;
        end
    end

    assign bus.pred_taken_out      = taken;
    assign bus.pred_pc_out         = pc;
    assign bus.pred_indx_out       = idx;
    assign bus.pred_ready_out      = ready;
    assign bus.pred_miss_count_out = miss_count;

endmodule

// File: tb/tb_pred_gshare.sv
// Bench for pred_gshare: a gshare instance (HIST_BITS=2) and a bimodal one
// (HIST_BITS=0, miss counter preset near saturation) share the same stimulus.
module tb_pred_gshare;
    import pred_pkg::*;

    localparam int          IB           = 4;
    localparam int          DEPTH        = 16;
    localparam logic [31:0] MISS_B_RESET = 32'hFFFF_FFFC;
    localparam logic [31:0] BEQ_M8       = 32'hFE000CE3;
    localparam logic [31:0] ADDI         = 32'h00100093;

    // ---------------- clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]   addr;
    logic [31:0]   ins;
    logic          we;
    logic [IB-1:0] ix_in;
    logic          tk_in;
    logic          misp;
    pred_state_t   st_a;
    pred_state_t   st_b;

    pred_gshare_if #(.INDEX_BITS(IB)) if_a ();
    pred_gshare_if #(.INDEX_BITS(IB)) if_b ();

    assign if_a.pred_addr_in         = addr;
    assign if_a.pred_ins_in          = ins;
    assign if_a.pred_write_enable_in = we;
    assign if_a.pred_indx_in         = ix_in;
    assign if_a.pred_taken_in        = tk_in;
    assign if_a.pred_mispredict_in   = misp;
    assign if_b.pred_addr_in         = addr;
    assign if_b.pred_ins_in          = ins;
    assign if_b.pred_write_enable_in = we;
    assign if_b.pred_indx_in         = ix_in;
    assign if_b.pred_taken_in        = tk_in;
    assign if_b.pred_mispredict_in   = misp;

    pred_gshare #(.INDEX_BITS(IB), .HIST_BITS(2), .INIT_STATE(2'b01)) dut_a (
        .pred_clock_in (clk),
        .pred_reset_in (rst),
        .bus           (if_a),
        .fsm_state     (st_a)
    );

    pred_gshare #(.INDEX_BITS(IB), .HIST_BITS(0), .INIT_STATE(2'b01),
                  .MISS_RESET(MISS_B_RESET)) dut_b (
        .pred_clock_in (clk),
        .pred_reset_in (rst),
        .bus           (if_b),
        .fsm_state     (st_b)
    );

    // ---------------- scoreboard
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model
    int     m_cnt_a [DEPTH];
    int     m_cnt_b [DEPTH];
    int     m_ghr;
    longint m_miss_a;
    longint m_miss_b;
    bit     m_ready;

    function automatic int imm_of(input logic [31:0] i);
        int op;
        int v;
        op = int'((i >> 2) & 32'h1F);
        v  = 0;
        if (op == 24) begin
            v = int'((i >> 8) & 32'hF) * 2 + int'((i >> 25) & 32'h3F) * 32
              + int'((i >> 7) & 32'h1) * 2048;
            if (i[31]) v = v - 4096;
        end else if (op == 27) begin
            v = int'((i >> 21) & 32'h3FF) * 2 + int'((i >> 20) & 32'h1) * 2048
              + int'((i >> 12) & 32'hFF) * 4096;
            if (i[31]) v = v - 1048576;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_cnt_a[k] = 1;
            m_cnt_b[k] = 1;
        end
        m_ghr    = 0;
        m_miss_a = 0;
        m_miss_b = longint'(MISS_B_RESET);
        m_ready  = 1'b0;
    endtask

    task automatic model_check(input string tag);
        int          ia;
        int          ib;
        int          op;
        bit          tka;
        bit          tkb;
        logic [31:0] pa;
        logic [31:0] pb;
        ib  = int'((addr >> 2) & 32'hF);
        ia  = ib ^ (m_ghr & 3);
        op  = int'((ins >> 2) & 32'h1F);
        tka = m_ready && (op == 27 || (op == 24 && m_cnt_a[ia] >= 2));
        tkb = m_ready && (op == 27 || (op == 24 && m_cnt_b[ib] >= 2));
        pa  = tka ? addr + 32'(imm_of(ins)) : 32'h0;
        pb  = tkb ? addr + 32'(imm_of(ins)) : 32'h0;
        chk({tag, "/a_taken"}, 32'(if_a.pred_taken_out), 32'(tka));
        chk({tag, "/a_pc"},    if_a.pred_pc_out, pa);
        chk({tag, "/a_indx"},  32'(if_a.pred_indx_out), 32'(ia));
        chk({tag, "/a_ready"}, 32'(if_a.pred_ready_out), 32'(m_ready));
        chk({tag, "/a_miss"},  if_a.pred_miss_count_out, 32'(m_miss_a));
        chk({tag, "/b_taken"}, 32'(if_b.pred_taken_out), 32'(tkb));
        chk({tag, "/b_pc"},    if_b.pred_pc_out, pb);
        chk({tag, "/b_indx"},  32'(if_b.pred_indx_out), 32'(ib));
        chk({tag, "/b_ready"}, 32'(if_b.pred_ready_out), 32'(m_ready));
        chk({tag, "/b_miss"},  if_b.pred_miss_count_out, 32'(m_miss_b));
    endtask

    // One rising edge; the model absorbs the feedback presented before it.
    task automatic step();
        @(posedge clk);
        if (m_ready && we) begin
            m_cnt_a[ix_in] = tk_in ? ((m_cnt_a[ix_in] < 3) ? m_cnt_a[ix_in] + 1 : 3)
                                   : ((m_cnt_a[ix_in] > 0) ? m_cnt_a[ix_in] - 1 : 0);
            m_cnt_b[ix_in] = tk_in ? ((m_cnt_b[ix_in] < 3) ? m_cnt_b[ix_in] + 1 : 3)
                                   : ((m_cnt_b[ix_in] > 0) ? m_cnt_b[ix_in] - 1 : 0);
            m_ghr = ((m_ghr << 1) | int'(tk_in)) & 3;
            if (misp) begin
                if (m_miss_a < 64'hFFFF_FFFF) m_miss_a++;
                if (m_miss_b < 64'hFFFF_FFFF) m_miss_b++;
            end
        end
        #1;
    endtask

    task automatic do_init(input string tag);
        for (int e = 1; e <= DEPTH; e++) begin
            step();
            if (e == DEPTH) m_ready = 1'b1;
            chk({tag, "/ready_a"}, 32'(if_a.pred_ready_out), 32'(e == DEPTH));
            model_check(tag);
        end
    endtask

    // ---------------- vector table
    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        logic        taken;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'h0000_0040, BEQ_M8,        1'b0, 32'h0};
        vecs[1] = '{32'h0000_0200, 32'h0080006F,  1'b1, 32'h0000_0208};
        vecs[2] = '{32'h0000_0300, ADDI,          1'b0, 32'h0};
        vecs[3] = '{32'h0000_1000, 32'hFFDFF06F,  1'b1, 32'h0000_0FFC};
        vecs[4] = '{32'h0000_0000, 32'hFFDFF06F,  1'b1, 32'hFFFF_FFFC};
        vecs[5] = '{32'h0000_0114, BEQ_M8,        1'b0, 32'h0};

        // Reset with feedback asserted: it must be ignored during init.
        addr  = 32'h54;
        ins   = BEQ_M8;
        we    = 1'b1;
        ix_in = 4'd5;
        tk_in = 1'b1;
        misp  = 1'b1;
        rst   = 1'b1;
        model_reset();
        #12;
        chk("reset/indx_a", 32'(if_a.pred_indx_out), 32'd5);
        chk("reset/state_a", 32'(st_a), 32'(INIT));
        chk("reset/miss_b", if_b.pred_miss_count_out, MISS_B_RESET);
        model_check("reset");
        @(negedge clk);
        rst = 1'b0;
        do_init("init");
        we   = 1'b0;
        misp = 1'b0;
        chk("init/state_b", 32'(st_b), 32'(RUN));

        for (int v = 0; v < 6; v++) begin
            addr = vecs[v].addr;
            ins  = vecs[v].ins;
            #1;
            chk($sformatf("vec%0d/taken", v), 32'(if_b.pred_taken_out), 32'(vecs[v].taken));
            chk($sformatf("vec%0d/pc", v), if_b.pred_pc_out, vecs[v].pc);
            model_check($sformatf("vec%0d", v));
        end

        // Two taken outcomes fill the 2-bit history.
        we = 1'b1; tk_in = 1'b1; ix_in = 4'd0;
        step();
        step();
        we = 1'b0; addr = 32'h0; ins = ADDI;
        #1;
        chk("ghr/indx_a", 32'(if_a.pred_indx_out), 32'd3);
        chk("ghr/indx_b", 32'(if_b.pred_indx_out), 32'd0);
        model_check("ghr");

        // Counter at idx 5 walks 01->10->11->11, then back down to 01.
        addr = 32'h114; ins = BEQ_M8; ix_in = 4'd5; tk_in = 1'b1; we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("inc%0d/taken_b", k), 32'(if_b.pred_taken_out), 32'd1);
        end
        we = 1'b0;
        #1;
        chk("idx5/pc_b", if_b.pred_pc_out, 32'h0000_010C);
        model_check("idx5");
        we = 1'b1; tk_in = 1'b0;
        step();
        chk("dec0/taken_b", 32'(if_b.pred_taken_out), 32'd1);
        step();
        chk("dec1/taken_b", 32'(if_b.pred_taken_out), 32'd0);
        model_check("dec");

        // Lookup and update on the same index in one cycle.
        tk_in = 1'b1;
        #1;
        chk("bypass/old_b", 32'(if_b.pred_taken_out), 32'd0);
        step();
        we = 1'b0;
        #1;
        chk("bypass/new_b", 32'(if_b.pred_taken_out), 32'd1);
        model_check("bypass");

        // Mispredict pulses drive the preset counter into saturation.
        we = 1'b1; misp = 1'b1; ix_in = 4'd9; tk_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("miss%0d/b", k), if_b.pred_miss_count_out,
                (k >= 3) ? 32'hFFFF_FFFF : MISS_B_RESET + 32'(k));
            model_check("miss");
        end
        we = 1'b0; misp = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] raw;
            raw = $urandom;
            case ($urandom_range(0, 3))
                0:       ins = (raw & ~32'h7F) | 32'h63;
                1:       ins = (raw & ~32'h7F) | 32'h6F;
                2:       ins = raw;
                default: ins = ADDI;
            endcase
            addr  = $urandom;
            we    = 1'($urandom_range(0, 1));
            tk_in = 1'($urandom_range(0, 1));
            misp  = ($urandom_range(0, 3) == 0);
            ix_in = 4'($urandom_range(0, DEPTH - 1));
            #1;
            model_check("rand");
            step();
        end
        we = 1'b0; misp = 1'b0;

        // Reset from RUN, then again mid-init at ptr 7.
        rst = 1'b1;
        #1;
        model_reset();
        model_check("rst_run");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            model_check("partial_init");
        end
        rst = 1'b1;
        #2;
        chk("rst_mid/state_a", 32'(st_a), 32'(INIT));
        model_check("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        do_init("reinit");
        addr = 32'h114; ins = BEQ_M8;
        #1;
        chk("reinit/taken_b", 32'(if_b.pred_taken_out), 32'd0);
        model_check("reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
